fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO write port among `NUM_REQ` requesters. Each requester presents data on a valid/ready handshake. The block grants one requester at a time, for a burst of up to `MAX_BURST` words, and drives the FIFO's `wr_en`/`din`. Writes are throttled by the FIFO `full` flag so no word is ever dropped. It sits directly in front of the `fifo` block, upstream of its write side.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each data word; must match the FIFO.
- `NUM_REQ`, 4, number of requesters; ≥2.
- `MAX_BURST`, 4, maximum words transferred per grant; ≥1.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ  bit i set: requester i has a word on its data slice.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  bit i set: requester i's word is accepted this cycle.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_din`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current owner.
- `busy`  out  1  high while a grant is held (GRANT state).

## Operation
Registered state:
- `state` (IDLE/GRANT)
- `owner` (width $clog2(NUM_REQ))
- `rr_ptr` (same width)
- `burst_cnt` (width $clog2(MAX_BURST+1))

IDLE:
- If any `req_valid` bit is set, pick the first set index scanning cyclically from `rr_ptr` upward, wrapping from NUM_REQ-1 to 0.
- On that edge: `owner` ← winner, `burst_cnt` ← 0, `state` ← GRANT.
- No transfer occurs in an IDLE cycle.

GRANT:
- Transfer condition `xfer` = `req_valid[owner]` && !`fifo_full`.
- On `xfer`: `fifo_wr_en`=1, `req_ready[owner]`=1, `fifo_din` = owner's data slice. All are combinational from `state`, `owner`, `req_valid`, `fifo_full`.
- `burst_cnt` increments on each `xfer`.
- Release to IDLE, with `rr_ptr` ← (`owner`+1) mod NUM_REQ, when either:
  - `xfer` occurs and `burst_cnt`+1 == MAX_BURST, or
  - `req_valid[owner]` is low (no transfer that cycle).
- `fifo_full` high with valid high: hold the grant, no write, no `burst_cnt` change. A stall does not consume burst budget.

Outputs outside GRANT, and for non-owner ready bits:
- `fifo_wr_en`=0, `req_ready`=0, `fifo_din`=0.
- `grant_id`=`owner`, `busy` = (state==GRANT).

Requester rules:
- Hold data stable while valid is high and ready is low.
- Valid may be withdrawn at any time. Withdrawing it ends the grant.

Word ordering per requester is preserved. Interleaving between requesters occurs only at burst boundaries.

## Timing
- Reset (`rst_n` low, takes effect immediately): `state`=IDLE, `owner`=0, `rr_ptr`=0, `burst_cnt`=0. Hence `fifo_wr_en`=0, `req_ready`=0, `fifo_din`=0, `grant_id`=0, `busy`=0.
- Reset mid-burst: outputs drop immediately. A word whose ready was high in the cycle reset asserted is not transferred. After release, arbitration restarts from requester 0.
- Arbitration latency: valid high in cycle N (state IDLE) → first possible write in cycle N+1.
- Peak throughput: MAX_BURST words per MAX_BURST+1 cycles, since every release costs one IDLE cycle, even if the same requester re-wins.
- `fifo_full` is sampled in the same cycle as `fifo_wr_en`. The FIFO flag updates the cycle after each write, so a write is never issued while `full` is high.
- A simultaneous FIFO read does not affect this block beyond the `fifo_full` value.

## Test plan
- Reset: `rst_n`=0 with all `req_valid`=1 → all outputs 0. Release with `req_valid`=0 → `busy` stays 0 and `fifo_wr_en` stays 0.
- Single requester 1 sends 6 words (0x10..0x15), MAX_BURST=4:
  - `busy` rises one cycle after valid.
  - 0x10..0x13 written on consecutive cycles, then 1 IDLE cycle.
  - Regrant to 1, then 0x14, 0x15 written.
  - FIFO contents are in order.
- All four requesters continuously valid → grant order 0,1,2,3,0, each burst exactly 4 writes with `grant_id` matching, one IDLE cycle between bursts.
- `fifo_full` forced high for 3 cycles after requester 0's 2nd word:
  - `fifo_wr_en`=0, `req_ready`=0, `busy`=1 throughout.
  - Words 3 and 4 are then written.
  - Release occurs after the 4th write.
- Requester 2 drops valid after 1 word → next cycle IDLE, `rr_ptr`=3. With requesters 0 and 3 valid → 3 is granted, then 0.
- Assert `rst_n` between clock edges mid-burst → `fifo_wr_en` and `busy` fall without waiting for an edge. After release with requesters 0 and 2 valid, 0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ requesters
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, win, idx, owner_nxt;
  logic [IW:0]     sum;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            xfer, rel, any_valid;
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  // descending scan so the lowest cyclic offset from rr_ptr wins
  always_comb begin
    win = rr_ptr_q;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      idx = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
      win = req_valid[idx] ? idx : win;
    end
  end
  assign any_valid = |req_valid;
  assign xfer      = (state_q == GRANT) && req_valid[owner_q] && !fifo_full;
  assign rel       = (state_q == GRANT) &&
                     (!req_valid[owner_q] || (xfer && burst_cnt_q == BW'(MAX_BURST - 1)));
  assign owner_nxt = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = xfer ? burst_cnt_q + 1'b1 : burst_cnt_q;
    if (state_q == IDLE && any_valid) begin
      state_d     = GRANT;
      owner_d     = win;
      burst_cnt_d = '0;
    end
    if (rel) begin
      state_d  = IDLE;
      rr_ptr_d = owner_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
  assign fifo_wr_en = xfer;
  assign fifo_din   = xfer ? data_a[owner_q] : '0;
  assign req_ready  = xfer ? (NUM_REQ'(1) << owner_q) : '0;
  assign grant_id   = owner_q;
  assign busy       = (state_q == GRANT);
endmodule
